output_drain: RTL and testbench
===============================

OUTPUT_DRAIN -- requirements
Module: output_drain

Interface
REQ-001 SHALL have parameter BUF_NUM, default `OUTPUT_BUF_NUM, the number of output-buffer entries to be drained.
REQ-002 SHALL have parameter DAT_W, default `PARTIAL_OUT_SIZE, the width of a signed partial-sum entry.
REQ-003 SHALL have parameter OUT_W, default 8, the width of the signed quantised result.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk_i, input, 1 bit: the clock.
REQ-006 SHALL have port rst_i, input, 1 bit: the synchronous active-high reset.
REQ-007 SHALL have port start_i, input, 1 bit: drain request, sampled only in IDLE.
REQ-008 SHALL have port cnt_i, input, $clog2(BUF_NUM)+1 bits: number of entries to drain.
REQ-009 SHALL have port shift_i, input, 5 bits: arithmetic right-shift amount.
REQ-010 SHALL have port relu_en_i, input, 1 bit: enables clamping negative values to zero.
REQ-011 SHALL have port out_sel_o, output, $clog2(BUF_NUM) bits: output-buffer read index.
REQ-012 SHALL have port out_dat_i, input, DAT_W bits: output-buffer read data, combinational from out_sel_o in the same cycle.
REQ-013 SHALL have port val_o, output, 1 bit: result valid.
REQ-014 SHALL have port rdy_i, input, 1 bit: downstream ready.
REQ-015 SHALL have port dat_o, output, OUT_W bits: quantised result.
REQ-016 SHALL have port idx_o, output, $clog2(BUF_NUM) bits: buffer index of dat_o.
REQ-017 SHALL have port busy_o, output, 1 bit: high in DRAIN and DONE.
REQ-018 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-019 SHALL implement the FSM states IDLE, DRAIN and DONE.
REQ-020 SHALL move IDLE->DRAIN on start_i=1 with cnt_i>0, and IDLE->DONE on start_i=1 with cnt_i=0.
REQ-021 SHALL latch cnt_i, shift_i and relu_en_i on start acceptance and hold them constant for the whole drain.
REQ-022 SHALL clamp a latched cnt_i greater than BUF_NUM to BUF_NUM.
REQ-023 SHALL ignore start_i in DRAIN and DONE.
REQ-024 SHALL use a read pointer that is 0 on entering DRAIN and drives out_sel_o.
REQ-025 SHALL capture the read entry into the single output register when the register is empty or is handshaking (val_o && rdy_i) in that cycle; the pointer then increments.
REQ-026 SHALL stop reading once the pointer has read cnt entries.
REQ-027 SHALL have a start-to-first-data latency of 2 cycles: start accepted at cycle T gives out_sel_o=0 at T+1 and val_o=1 with idx_o=0 at T+2.
REQ-028 SHALL sustain throughput of 1 result per cycle while rdy_i=1.
REQ-029 SHALL hold val_o, dat_o and idx_o stable while val_o=1 and rdy_i=0.
REQ-030 SHALL never deassert val_o without a handshake, except on reset.
REQ-031 SHALL go DRAIN->DONE the cycle after the handshake of entry cnt-1.
REQ-032 SHALL hold done_o=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-033 SHALL compute each result as: signed DAT_W input, then ReLU if enabled (x<0 -> 0), then arithmetic right shift by shift.
REQ-034 SHALL saturate each shifted result to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-035 SHALL not truncate intermediate results before saturation.
REQ-036 SHALL not handle buffer-content coherence; upstream SHALL NOT write entries being drained during DRAIN, and the block SHALL NOT detect such writes.

Reset
REQ-037 SHALL, on rst_i=1 at a clock edge, set the state to IDLE, val_o=0, done_o=0, busy_o=0, out_sel_o=0, dat_o=0, idx_o=0, and clear the latched parameters.
REQ-038 SHALL, on reset mid-drain, abandon the drain with no done_o pulse; the next start SHALL drain from entry 0.

Structure
REQ-039 SHALL place the FSM state enum and the OUT_W default constant in the shared NPU package; BUF_NUM and DAT_W SHALL keep their defaults from the global include macros.
REQ-040 SHALL implement ReLU, shift and saturation in one combinational sub-module, quant_sat, with parameters DAT_W and OUT_W.

Verification (DAT_W=32, OUT_W=8, BUF_NUM=16)
REQ-041 SHALL check reset: hold rst_i for 2 cycles -> val_o=0, busy_o=0, done_o=0, out_sel_o=0.
REQ-042 SHALL check a basic drain: buffer {100,-5,300,-300}, cnt 4, shift 0, relu 0, rdy_i=1 -> dat_o 100,-5,127,-128 on 4 consecutive cycles, idx_o 0..3, then done_o one cycle.
REQ-043 SHALL check ReLU and shift: buffer {-8,20,1000}, cnt 3, shift 2, relu 1 -> dat_o 0,5,127.
REQ-044 SHALL check backpressure: rdy_i=0 for 3 cycles while idx_o=1 is presented -> val_o=1 and dat_o/idx_o unchanged throughout; no entry lost or duplicated; total beats = 4.
REQ-045 SHALL check count boundaries: cnt_i=0 -> done_o at T+1 with no val_o; cnt_i=20 -> exactly 16 beats, idx_o 0..15.
REQ-046 SHALL check reset mid-drain: rst_i after 2 beats of an 8-entry drain -> val_o=0 and busy_o=0 next cycle with no done_o; a new start with cnt 2 -> idx_o 0,1.

Source files
------------

// File: rtl/output_drain_pkg.sv
// output_drain_pkg
//   Shared NPU definitions for the output-buffer drain block: the drain FSM
//   state encoding and the default width of the quantised result.
//   No ports (package).
package output_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_t;

  localparam int OUT_W_DEFAULT = 8;

endpackage

// File: rtl/output_drain_quant_sat.sv
// quant_sat
//   Combinational requantiser for one partial-sum entry: optional ReLU,
//   arithmetic right shift, then saturation to a signed OUT_W result.
//   The intermediate value stays DAT_W wide until the saturation compare.
// Ports
//   dat     in  DAT_W  signed partial sum
//   shift   in  5      arithmetic right-shift amount
//   relu_en in  1      clamp negative inputs to zero
//   res     out OUT_W  saturated signed result
module quant_sat #(
  parameter int DAT_W = 32,
  parameter int OUT_W = 8
) (
  input  logic [DAT_W-1:0] dat,
  input  logic [4:0]       shift,
  input  logic             relu_en,
  output logic [OUT_W-1:0] res
);

  localparam logic signed [DAT_W-1:0] SAT_MAX = DAT_W'(2**(OUT_W-1) - 1);
  // Bitwise inverse of 0..01..1 is 1..10..0, i.e. -2^(OUT_W-1).
  localparam logic signed [DAT_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DAT_W-1:0] x;
  logic signed [DAT_W-1:0] r;
  logic signed [DAT_W-1:0] s;

  always_comb begin
    x = signed'(dat);
    r = (relu_en && x[DAT_W-1]) ? '0 : x;
    s = r >>> shift;
    if (s > SAT_MAX) begin
      res = SAT_MAX[OUT_W-1:0];
    end else if (s < SAT_MIN) begin
      res = SAT_MIN[OUT_W-1:0];
    end else begin
      res = s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/output_drain.sv
// output_drain
//   Drains cnt entries of the NPU output buffer, requantises each one and
//   streams the results out through a single valid/ready output register.
//   Start is accepted in IDLE; cnt, shift and relu are latched then and held
//   for the whole drain. Reset is synchronous and active high.
// Ports
//   clk_i      in   clock
//   rst_i      in   synchronous active-high reset
//   start_i    in   drain request (IDLE only)
//   cnt_i      in   entries to drain (clamped to BUF_NUM)
//   shift_i    in   arithmetic right-shift amount
//   relu_en_i  in   clamp negative entries to zero
//   out_sel_o  out  output-buffer read index
//   out_dat_i  in   output-buffer read data (combinational from out_sel_o)
//   val_o      out  result valid
//   rdy_i      in   downstream ready
//   dat_o      out  quantised result
//   idx_o      out  buffer index of dat_o
//   busy_o     out  high in DRAIN and DONE
//   done_o     out  one-cycle completion pulse
`ifndef OUTPUT_BUF_NUM
`define OUTPUT_BUF_NUM 16
`endif
`ifndef PARTIAL_OUT_SIZE
`define PARTIAL_OUT_SIZE 32
`endif

// state | meaning
// IDLE  | waiting for start_i
// DRAIN | reading entries and presenting results
// DONE  | one-cycle completion pulse, then back to IDLE
module output_drain
  import output_drain_pkg::*;
#(
  parameter int BUF_NUM = `OUTPUT_BUF_NUM,
  parameter int DAT_W   = `PARTIAL_OUT_SIZE,
  parameter int OUT_W   = OUT_W_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [$clog2(BUF_NUM):0]   cnt_i,
  input  logic [4:0]                 shift_i,
  input  logic                       relu_en_i,
  output logic [$clog2(BUF_NUM)-1:0] out_sel_o,
  input  logic [DAT_W-1:0]           out_dat_i,
  output logic                       val_o,
  input  logic                       rdy_i,
  output logic [OUT_W-1:0]           dat_o,
  output logic [$clog2(BUF_NUM)-1:0] idx_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int IW = $clog2(BUF_NUM);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] BUF_NUM_C = CW'(BUF_NUM);

  drain_state_t state_q;
  drain_state_t state_d;

  logic [CW-1:0]    cnt_q;
  logic [4:0]       shift_q;
  logic             relu_q;
  // One bit wider than the index so it can reach cnt (== BUF_NUM) and stop.
  logic [CW-1:0]    ptr_q;
  logic             accept;
  logic             capture;
  logic             last_hs;
  logic [OUT_W-1:0] quant;

  quant_sat #(
    .DAT_W (DAT_W),
    .OUT_W (OUT_W)
  ) u_quant_sat (
    .dat     (out_dat_i),
    .shift   (shift_q),
    .relu_en (relu_q),
    .res     (quant)
  );

  assign out_sel_o = ptr_q[IW-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    last_hs = 1'b0;
    busy_o  = (state_q != ST_IDLE);
    done_o  = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = (cnt_i == '0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Refill the output register when it is empty or emptying this cycle.
        capture = (ptr_q < cnt_q) && (!val_o || rdy_i);
        // Everything read and the final result is being taken.
        last_hs = val_o && rdy_i && (ptr_q == cnt_q);
        if (last_hs) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      ptr_q   <= '0;
      val_o   <= 1'b0;
      dat_o   <= '0;
      idx_o   <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= (cnt_i > BUF_NUM_C) ? BUF_NUM_C : cnt_i;
        shift_q <= shift_i;
        relu_q  <= relu_en_i;
        ptr_q   <= '0;
      end else if (state_q == ST_DONE) begin
        ptr_q <= '0;
      end else if (capture) begin
        ptr_q <= ptr_q + 1'b1;
      end

      if (capture) begin
        val_o <= 1'b1;
        dat_o <= quant;
        idx_o <= ptr_q[IW-1:0];
      end else if (val_o && rdy_i) begin
        val_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_output_drain.sv
module tb_output_drain;

  localparam int BUF_NUM = 16;
  localparam int DAT_W   = 32;
  localparam int OUT_W   = 8;
  localparam int IW      = 4;
  localparam int CW      = 5;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [CW-1:0]    cnt_i;
  logic [4:0]       shift_i;
  logic             relu_en_i;
  logic [IW-1:0]    out_sel_o;
  logic [DAT_W-1:0] out_dat_i;
  logic             val_o;
  logic             rdy_i;
  logic [OUT_W-1:0] dat_o;
  logic [IW-1:0]    idx_o;
  logic             busy_o;
  logic             done_o;

  logic signed [31:0] mem [BUF_NUM];
  assign out_dat_i = mem[out_sel_o];

  always #5 clk = ~clk;

  output_drain #(
    .BUF_NUM (BUF_NUM),
    .DAT_W   (DAT_W),
    .OUT_W   (OUT_W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .cnt_i     (cnt_i),
    .shift_i   (shift_i),
    .relu_en_i (relu_en_i),
    .out_sel_o (out_sel_o),
    .out_dat_i (out_dat_i),
    .val_o     (val_o),
    .rdy_i     (rdy_i),
    .dat_o     (dat_o),
    .idx_o     (idx_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  typedef struct {
    int idx;
    int dat;
  } beat_t;

  int    vectors   = 0;
  int    errors    = 0;
  int    cyc       = 0;
  int    done_cnt  = 0;
  int    done_cyc  = 0;
  bit    rand_rdy  = 1'b0;
  beat_t exp_q[$];
  int    log_dat[$];
  int    log_idx[$];
  int    log_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: ReLU, arithmetic shift, saturate, all on a wide integer.
  function automatic int quant(longint x, int sh, bit relu);
    longint v;
    v = x;
    if (relu && v < 0) v = 0;
    v = v >>> sh;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic chk(string name, int act, int exp_v);
    vectors++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy();
    if (rand_rdy) rdy_i = ($urandom_range(0, 9) < 7);
    else rdy_i = 1'b1;
  endtask

  task automatic clear_logs();
    log_dat.delete();
    log_idx.delete();
    log_cyc.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < BUF_NUM; i++) begin
      if ($urandom_range(0, 1) == 0) mem[i] = $urandom;
      else mem[i] = $signed($urandom_range(0, 600)) - 300;
    end
  endtask

  // Leaves the bench at posedge+1 of the cycle after the acceptance edge.
  task automatic start_drain(int cnt, int sh, bit relu);
    int n;
    for (int i = 0; i < 100 && busy_o; i++) tick();
    chk("idle_before_start", int'(busy_o), 0);
    start_i   = 1'b1;
    cnt_i     = CW'(cnt);
    shift_i   = 5'(sh);
    relu_en_i = relu;
    @(posedge clk);
    n = (cnt > BUF_NUM) ? BUF_NUM : cnt;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{idx: i, dat: quant(mem[i], sh, relu)});
    end
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      set_rdy();
      if (rand_rdy) begin
        // Noise on the request inputs while busy must have no effect.
        start_i   = ($urandom_range(0, 3) == 0);
        cnt_i     = CW'($urandom_range(0, 31));
        shift_i   = 5'($urandom_range(0, 31));
        relu_en_i = 1'($urandom_range(0, 1));
      end
      tick();
    end
    start_i = 1'b0;
    rdy_i   = 1'b1;
    chk("done_seen", int'(done_cnt != d0), 1);
    tick();
    tick();
    chk("done_single_pulse", done_cnt - d0, 1);
  endtask

  // Compare process: every cycle out of reset.
  logic            p_ok = 1'b0;
  logic            pv, pr;
  logic [OUT_W-1:0] pd;
  logic [IW-1:0]   pi;
  beat_t           mon_b;

  always @(negedge clk) begin
    if (rst_i) begin
      p_ok <= 1'b0;
    end else begin
      if (p_ok && pv && !pr) begin
        chk("stall_val", int'(val_o), 1);
        chk("stall_dat", int'(dat_o), int'(pd));
        chk("stall_idx", int'(idx_o), int'(pi));
      end
      if (val_o && rdy_i) begin
        chk("beat_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_b = exp_q.pop_front();
          chk("beat_idx", int'(idx_o), mon_b.idx);
          chk("beat_dat", int'($signed(dat_o)), mon_b.dat);
        end
        log_dat.push_back(int'($signed(dat_o)));
        log_idx.push_back(int'(idx_o));
        log_cyc.push_back(cyc);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_all_beats", exp_q.size(), 0);
        chk("done_no_val", int'(val_o), 0);
      end
      chk("val_implies_busy", int'(busy_o || !val_o), 1);
      p_ok <= 1'b1;
      pv   <= val_o;
      pr   <= rdy_i;
      pd   <= dat_o;
      pi   <= idx_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int lit4[4];
    int lit3[3];

    rst_i     = 1'b1;
    start_i   = 1'b0;
    cnt_i     = '0;
    shift_i   = '0;
    relu_en_i = 1'b0;
    rdy_i     = 1'b1;
    for (int i = 0; i < BUF_NUM; i++) mem[i] = 0;

    // Pin the reference model to hand-computed values.
    chk("model_pass",      quant(100, 0, 0), 100);
    chk("model_sat_hi",    quant(300, 0, 0), 127);
    chk("model_sat_lo",    quant(-300, 0, 0), -128);
    chk("model_relu",      quant(-8, 2, 1), 0);
    chk("model_shift",     quant(20, 2, 1), 5);
    chk("model_neg_shift", quant(-7, 1, 0), -4);

    // Reset held for two cycles.
    tick();
    tick();
    @(negedge clk);
    chk("rst_val",     int'(val_o), 0);
    chk("rst_busy",    int'(busy_o), 0);
    chk("rst_done",    int'(done_o), 0);
    chk("rst_out_sel", int'(out_sel_o), 0);
    chk("rst_dat",     int'(dat_o), 0);
    chk("rst_idx",     int'(idx_o), 0);
    tick();
    rst_i = 1'b0;
    tick();

    // Basic drain with latency and consecutive-beat checks.
    mem[0] = 100; mem[1] = -5; mem[2] = 300; mem[3] = -300;
    lit4 = '{100, -5, 127, -128};
    clear_logs();
    start_drain(4, 0, 0);
    @(negedge clk);
    chk("lat_out_sel_t1", int'(out_sel_o), 0);
    chk("lat_busy_t1",    int'(busy_o), 1);
    chk("lat_val_t1",     int'(val_o), 0);
    @(negedge clk);
    chk("lat_val_t2", int'(val_o), 1);
    chk("lat_idx_t2", int'(idx_o), 0);
    wait_done(50);
    chk("basic_beats", log_dat.size(), 4);
    if (log_dat.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("basic_dat", log_dat[i], lit4[i]);
        chk("basic_idx", log_idx[i], i);
        chk("basic_consecutive", log_cyc[i] - log_cyc[0], i);
      end
      chk("basic_done_after_last", done_cyc - log_cyc[3], 1);
    end

    // ReLU and shift.
    mem[0] = -8; mem[1] = 20; mem[2] = 1000;
    lit3 = '{0, 5, 127};
    clear_logs();
    start_drain(3, 2, 1);
    wait_done(50);
    chk("relu_beats", log_dat.size(), 3);
    if (log_dat.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("relu_dat", log_dat[i], lit3[i]);
    end

    // Backpressure on idx 1 for three cycles.
    mem[0] = 10; mem[1] = -20; mem[2] = 30; mem[3] = -40;
    lit4 = '{10, -20, 30, -40};
    clear_logs();
    rdy_i = 1'b1;
    start_drain(4, 0, 0);
    for (int i = 0; i < 20 && !(val_o && idx_o == 1); i++) tick();
    chk("bp_reached_idx1", int'(val_o && idx_o == 1), 1);
    rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_val", int'(val_o), 1);
      chk("bp_idx", int'(idx_o), 1);
      chk("bp_dat", int'($signed(dat_o)), -20);
      tick();
    end
    rdy_i = 1'b1;
    wait_done(50);
    chk("bp_beats", log_dat.size(), 4);
    if (log_dat.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("bp_dat_seq", log_dat[i], lit4[i]);
        chk("bp_idx_seq", log_idx[i], i);
      end
    end

    // cnt = 0: done at T+1, no data.
    clear_logs();
    d0 = done_cnt;
    start_drain(0, 0, 0);
    @(negedge clk);
    chk("cnt0_done", int'(done_o), 1);
    chk("cnt0_val",  int'(val_o), 0);
    tick();
    @(negedge clk);
    chk("cnt0_idle", int'(busy_o), 0);
    chk("cnt0_pulses", done_cnt - d0, 1);
    chk("cnt0_beats", log_dat.size(), 0);
    tick();

    // cnt = 20 clamps to 16.
    fill_random();
    clear_logs();
    rand_rdy = 1'b1;
    start_drain(20, 0, 0);
    wait_done(400);
    chk("cnt20_beats", log_idx.size(), 16);
    if (log_idx.size() == 16) begin
      for (int i = 0; i < 16; i++) chk("cnt20_idx", log_idx[i], i);
    end
    rand_rdy = 1'b0;

    // Reset in the middle of an 8-entry drain.
    fill_random();
    clear_logs();
    rdy_i = 1'b1;
    start_drain(8, 0, 0);
    for (int i = 0; i < 20 && log_dat.size() < 2; i++) tick();
    chk("mid_two_beats", log_dat.size(), 2);
    rst_i = 1'b1;
    exp_q.delete();
    d0 = done_cnt;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("mid_rst_val",  int'(val_o), 0);
    chk("mid_rst_busy", int'(busy_o), 0);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rst_no_done", done_cnt - d0, 0);
    fill_random();
    clear_logs();
    start_drain(2, 0, 0);
    wait_done(50);
    chk("restart_beats", log_idx.size(), 2);
    if (log_idx.size() == 2) begin
      chk("restart_idx0", log_idx[0], 0);
      chk("restart_idx1", log_idx[1], 1);
    end

    // Randomized drains with random backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 16; k++) begin
      int c, sh, n;
      bit rl;
      fill_random();
      clear_logs();
      c  = $urandom_range(0, 20);
      sh = ($urandom_range(0, 4) == 0) ? 31 : $urandom_range(0, 12);
      rl = 1'($urandom_range(0, 1));
      n  = (c > BUF_NUM) ? BUF_NUM : c;
      start_drain(c, sh, rl);
      wait_done(400);
      chk("rand_beats", log_idx.size(), n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
